bus_fifo_port: RTL and testbench
================================

# bus_fifo_port

Memory-mapped streaming I/O responder on the shared CPU/DMA bus: a two-word register window whose data word pops an RX FIFO on bus reads and pushes a TX FIFO on bus writes. It is the bus target for both initiators (CPU `lw`/`sw` and DMA copy transfers), and it gives external logic a valid/ready stream in each direction. It sits on `address_Bus`/`Data_Bus` next to the RAM and the fixed I/O registers, and it decodes its own addresses.

## Interface
- `BASE_ADDR`, default 1010: address of the DATA word; the STATUS word is at `BASE_ADDR+1`.
- `DEPTH`, default 8: entries per FIFO; must be a power of 2, from 2 to 128.
- `CLK`  in  1: the single clock; every register updates on its rising edge.
- `RST_N`  in  1: asynchronous, active-low reset.
- `address_Bus`  in  32: bus address, driven by whichever initiator owns the bus.
- `Data_Bus`  inout  32: shared data bus; this block drives it only during its own read hits, otherwise high-Z.
- `Read_CPU`, `Write_CPU`  in  1: CPU strobes.
- `Read_DMA`, `Write_DMA`  in  1: DMA strobes.
- `tx_data`  out  32: head of the TX FIFO.
- `tx_valid`  out  1: TX FIFO is not empty.
- `tx_ready`  in  1: external sink accepts `tx_data` this cycle.
- `rx_data`  in  32: word from the external source.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: RX FIFO is not full.

## Operation
- Strobes: `rd = Read_CPU|Read_DMA`, `wr = Write_CPU|Write_DMA`.
- Hits: `hit_d = (address_Bus==BASE_ADDR)`, `hit_s = (address_Bus==BASE_ADDR+1)`. Full 32-bit compare; no aliasing.
- Read and write high in the same cycle: the read is performed, the write is ignored and `proto_err` is set.
- DATA read:
  - `Data_Bus` = RX head, or 0 if RX is empty.
  - At the sampling edge the RX entry is popped; if RX was empty, `rx_underflow` is set instead.
- DATA write: `Data_Bus` is pushed into TX. If TX is full, the word is dropped and `tx_overflow` is set.
- STATUS read returns:
  - [0] RX non-empty
  - [1] TX full
  - [2] `rx_underflow`
  - [3] `tx_overflow`
  - [4] `proto_err`
  - [15:8] RX count
  - [23:16] TX count
  - all other bits 0
- STATUS write: `Data_Bus[4:2]` are write-1-to-clear for `proto_err`, `tx_overflow` and `rx_underflow`. If a sticky bit is set and cleared in the same cycle, set wins. All other bits are ignored.
- External RX side:
  - Push when `rx_valid & rx_ready`.
  - `rx_ready = (rx_count != DEPTH)`, computed from the registered count only.
- External TX side:
  - Pop when `tx_valid & tx_ready`.
  - `tx_valid = (tx_count != 0)`; `tx_data` = TX head.
- FIFO storage: circular buffers, with `log2(DEPTH)`-bit pointers that wrap modulo `DEPTH`. Counts are `log2(DEPTH)+1` bits and are zero-extended into the STATUS fields.
- Simultaneous push and pop on the same FIFO: both happen and the count is unchanged.
  - Full TX with a bus write and an external pop in the same cycle: the write is still dropped and the overflow flag set, because fullness is judged on the registered count.
  - Empty RX with a bus read and an external push in the same cycle: the read returns 0 with underflow, and the pushed word is retained.
- Reset (async assert): both FIFOs empty, pointers 0, all sticky bits 0, `tx_valid`=0, `rx_ready`=1, `Data_Bus` high-Z. FIFO storage contents are don't-care.
- Reset asserted mid-access aborts the access; no partial push or pop survives.

## Timing
- The bus is sampled at every rising edge of `CLK`. A strobe held high for N cycles is N accesses, so initiators must pulse strobes for exactly one cycle per access.
- Read data path:
  - Combinational from registered FIFO state: `Data_Bus` is valid in the same cycle the strobe and address are presented.
  - The pop takes effect at the closing edge, so the next head appears one cycle later.
- Write path: `Data_Bus` is captured at the edge where `wr & hit_d`. `tx_valid` rises one cycle after the push into an empty TX.
- RX path: a word pushed at edge k is readable by a bus access in cycle k+1. The STATUS RX count reflects the push in the same cycle k+1.
- The `Data_Bus` driver enable is purely `rd & (hit_d|hit_s) & RST_N`. There is no drive in any other cycle, so there is no contention with the RAM, the I/O registers or the initiators.

## Test plan
- Reset, then STATUS read → 0x00000000; `tx_valid`=0, `rx_ready`=1, `Data_Bus` high-Z with no strobe.
- Three CPU writes to 1010 of 0xA, 0xB, 0xC with `tx_ready`=0 → STATUS[23:16]=3. Then raise `tx_ready` → `tx_data` is 0xA, 0xB, 0xC on consecutive cycles, after which `tx_valid`=0.
- Push 8 RX words 1..8 → `rx_ready`=0 and a 9th word is not accepted. DMA reads 1010 ×8 → return 1..8; a 9th read returns 0 and sets STATUS[2]. Writing 0x4 to 1011 clears it.
- Nine writes with `tx_ready`=0 → the 9th is dropped, STATUS[3]=1, TX count=8, and the head is still the first word.
- RX count 8 with a bus read and `rx_valid`=1 in the same cycle → the pop happens, the push is refused, and the count goes to 7. TX count 4 with a push and `tx_ready` in the same cycle → count stays 4.
- `Read_CPU`=`Write_CPU`=1 at 1010 → read performed, no TX push, STATUS[4]=1. Assert `RST_N` low mid-sequence → all counts 0 and sticky bits cleared immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_fifo_port_if.sv
// bus_fifo_port_if: address/strobe bus plus the two external streams.
// The shared Data_Bus stays a plain inout on the block.
interface bus_fifo_port_if;
    logic [31:0] address_Bus;
    logic        Read_CPU;
    logic        Write_CPU;
    logic        Read_DMA;
    logic        Write_DMA;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  address_Bus, Read_CPU, Write_CPU, Read_DMA, Write_DMA,
        input  tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, rx_ready
    );

    modport master (
        output address_Bus, Read_CPU, Write_CPU, Read_DMA, Write_DMA,
        output tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/bus_fifo_port.sv
// bus_fifo_port: two-word memory-mapped window over an RX and a TX FIFO.
// DATA read pops RX, DATA write pushes TX, STATUS reports counts and flags.
module bus_fifo_port #(
    parameter logic [31:0] BASE_ADDR = 32'd1010,
    parameter int          DEPTH     = 8
) (
    input  logic     CLK,
    input  logic     RST_N,
    inout  wire [31:0] Data_Bus,
    bus_fifo_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   rx_mem [DEPTH];
    logic [31:0]   tx_mem [DEPTH];
    logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0] rx_count, tx_count;
    logic [2:0]    sticky;

    logic rd, wr, wr_ok, hit_d, hit_s;
    logic rx_empty, tx_full;
    logic rx_push, rx_pop, tx_push, tx_pop;
    logic [2:0]  set_bits, clr_bits;
    logic [31:0] status, rd_word;
    logic        drive;

    assign rd    = bus.Read_CPU | bus.Read_DMA;
    assign wr    = bus.Write_CPU | bus.Write_DMA;
    assign wr_ok = wr & ~rd;
    assign hit_d = (bus.address_Bus == BASE_ADDR);
    assign hit_s = (bus.address_Bus == BASE_ADDR + 32'd1);

    assign rx_empty = (rx_count == '0);
    assign tx_full  = (tx_count == FULL);

    assign rx_pop  = rd & hit_d & ~rx_empty;
    assign rx_push = bus.rx_valid & bus.rx_ready;
    assign tx_push = wr_ok & hit_d & ~tx_full;
    assign tx_pop  = bus.tx_valid & bus.tx_ready;

    assign bus.rx_ready = (rx_count != FULL);
    assign bus.tx_valid = (tx_count != '0);
    assign bus.tx_data  = tx_mem[tx_rp];

    // sticky order {proto_err, tx_overflow, rx_underflow} matches Data_Bus[4:2]
    assign set_bits = {rd & wr & (hit_d | hit_s),
                       wr_ok & hit_d & tx_full,
                       rd & hit_d & rx_empty};
    assign clr_bits = (wr_ok & hit_s) ? Data_Bus[4:2] : 3'b000;

    assign status  = {8'h00, 8'(tx_count), 8'(rx_count),
                      3'b000, sticky, tx_full, ~rx_empty};
    assign rd_word = hit_d ? (rx_empty ? 32'h0 : rx_mem[rx_rp]) : status;
    assign drive   = rd & (hit_d | hit_s) & RST_N;
    assign Data_Bus = drive ? rd_word : 'z;

    // FIFO storage has no reset; only pointers and counts define contents
    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wp] <= bus.rx_data;
        if (tx_push) tx_mem[tx_wp] <= Data_Bus;
    end

    // RX pointers and occupancy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // sticky error flags: write-1-to-clear, a same-cycle set wins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sticky <= '0;
        else        sticky <= (sticky & ~clr_bits) | set_bits;
    end
endmodule

// File: tb/tb_bus_fifo_port.sv
// tb_bus_fifo_port: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_bus_fifo_port;
    localparam int DEPTH = 8;
    localparam logic [31:0] DA = 32'd1010;
    localparam logic [31:0] SA = 32'd1011;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    wire [31:0] Data_Bus;
    logic [31:0] bus_drv = '0;
    logic bus_en = 1'b0;
    assign Data_Bus = bus_en ? bus_drv : 'z;

    bus_fifo_port_if bus();

    bus_fifo_port #(.BASE_ADDR(DA), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .Data_Bus(Data_Bus),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model
    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    bit m_udf, m_ovf, m_perr;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = (32'(txq.size()) << 16) | (32'(rxq.size()) << 8);
        s[4] = m_perr;
        s[3] = m_ovf;
        s[2] = m_udf;
        s[1] = (txq.size() == DEPTH);
        s[0] = (rxq.size() != 0);
        return s;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rxq.delete();
            txq.delete();
            m_udf = 0; m_ovf = 0; m_perr = 0;
        end else begin : upd
            bit r, w, hd, hs, su, so, sp;
            int nrx, ntx;
            r   = bus.Read_CPU | bus.Read_DMA;
            w   = bus.Write_CPU | bus.Write_DMA;
            hd  = (bus.address_Bus == DA);
            hs  = (bus.address_Bus == SA);
            nrx = rxq.size();
            ntx = txq.size();
            su = 0; so = 0; sp = 0;
            if (r && w && (hd || hs)) sp = 1;
            if (r && hd) begin
                if (nrx > 0) void'(rxq.pop_front());
                else su = 1;
            end
            if (bus.rx_valid && nrx < DEPTH) rxq.push_back(bus.rx_data);
            if (bus.tx_ready && ntx > 0) void'(txq.pop_front());
            if (w && !r && hd) begin
                if (ntx < DEPTH) txq.push_back(Data_Bus);
                else so = 1;
            end
            if (w && !r && hs) begin
                if (Data_Bus[2]) m_udf = 0;
                if (Data_Bus[3]) m_ovf = 0;
                if (Data_Bus[4]) m_perr = 0;
            end
            m_udf  = m_udf | su;
            m_ovf  = m_ovf | so;
            m_perr = m_perr | sp;
        end
    end

    // compare process, mid-cycle
    always @(negedge CLK) begin
        if (RST_N) begin : cmp
            bit r, hd, hs;
            r  = bus.Read_CPU | bus.Read_DMA;
            hd = (bus.address_Bus == DA);
            hs = (bus.address_Bus == SA);
            chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, txq.size() != 0});
            if (txq.size() != 0) chk("tx_data", bus.tx_data, txq[0]);
            chk("rx_ready", {31'b0, bus.rx_ready}, {31'b0, rxq.size() < DEPTH});
            if (r && hd)
                chk("rd_data", Data_Bus, rxq.size() != 0 ? rxq[0] : 32'h0);
            else if (r && hs)
                chk("rd_status", Data_Bus, m_status());
            else if (bus_en)
                chk("bus_free", Data_Bus, bus_drv);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d, input bit dma);
        bus.address_Bus = addr;
        bus.Write_DMA = dma;
        bus.Write_CPU = !dma;
        bus_drv = d;
        bus_en = 1'b1;
        tick();
        bus.Write_DMA = 0;
        bus.Write_CPU = 0;
        bus_en = 1'b0;
        bus.address_Bus = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, input bit dma, output logic [31:0] d);
        bus.address_Bus = addr;
        bus.Read_DMA = dma;
        bus.Read_CPU = !dma;
        @(negedge CLK);
        d = Data_Bus;
        tick();
        bus.Read_DMA = 0;
        bus.Read_CPU = 0;
        bus.address_Bus = '0;
    endtask

    logic [31:0] d;

    initial begin
        bus.address_Bus = '0;
        bus.Read_CPU = 0; bus.Write_CPU = 0;
        bus.Read_DMA = 0; bus.Write_DMA = 0;
        bus.tx_ready = 0;
        bus.rx_data = '0;
        bus.rx_valid = 0;

        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        // reset state
        chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("rst_rx_ready", {31'b0, bus.rx_ready}, 32'd1);
        bus_drv = 32'h5A5A_1234;
        bus_en = 1'b1;
        @(negedge CLK);
        chk("rst_bus_idle", Data_Bus, 32'h5A5A_1234);
        tick();
        bus_en = 1'b0;
        bus_rd(SA, 0, d);
        chk("rst_status", d, 32'h0);

        // three TX writes then drain
        bus_wr(DA, 32'hA, 0);
        bus_wr(DA, 32'hB, 0);
        bus_wr(DA, 32'hC, 0);
        bus_rd(SA, 0, d);
        chk("tx3_status", d, 32'h0003_0000);
        bus.tx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("tx_seq", bus.tx_data, 32'hA + 32'(i));
            tick();
        end
        @(negedge CLK);
        chk("tx_drained", {31'b0, bus.tx_valid}, 32'd0);
        tick();
        bus.tx_ready = 0;

        // fill RX, refuse 9th, drain by DMA, underflow
        bus.rx_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            bus.rx_data = 32'(i);
            tick();
        end
        bus.rx_data = 32'd9;
        @(negedge CLK);
        chk("rx_full_ready", {31'b0, bus.rx_ready}, 32'd0);
        tick();
        bus.rx_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            bus_rd(DA, 1, d);
            chk("rx_seq", d, 32'(i));
        end
        bus_rd(DA, 1, d);
        chk("rx_empty_rd", d, 32'h0);
        bus_rd(SA, 0, d);
        chk("udf_status", d, 32'h0000_0004);
        bus_wr(SA, 32'h4, 0);
        bus_rd(SA, 0, d);
        chk("udf_cleared", d, 32'h0);

        // TX overflow
        for (int i = 1; i <= 9; i++) bus_wr(DA, 32'h100 + 32'(i), 0);
        bus_rd(SA, 0, d);
        chk("ovf_status", d, 32'h0008_000A);
        chk("ovf_head", bus.tx_data, 32'h101);
        // full TX, write plus external pop: write still dropped
        bus.address_Bus = DA;
        bus.Write_CPU = 1;
        bus_drv = 32'h1FF;
        bus_en = 1;
        bus.tx_ready = 1;
        tick();
        bus.Write_CPU = 0;
        bus_en = 0;
        bus.tx_ready = 0;
        bus.address_Bus = '0;
        bus_wr(SA, 32'h8, 1);
        bus.tx_ready = 1;
        repeat (3) tick();
        bus.tx_ready = 0;
        // push and pop with count 4
        bus.address_Bus = DA;
        bus.Write_DMA = 1;
        bus_drv = 32'h200;
        bus_en = 1;
        bus.tx_ready = 1;
        tick();
        bus.Write_DMA = 0;
        bus_en = 0;
        bus.tx_ready = 0;
        bus.address_Bus = '0;
        bus_rd(SA, 0, d);
        chk("tx_pushpop", d, 32'h0004_0000);
        chk("tx_head_after", bus.tx_data, 32'h106);

        // full RX, read plus external push
        bus.rx_valid = 1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 32'd20 + 32'(i);
            tick();
        end
        bus.rx_data = 32'd99;
        bus_rd(DA, 1, d);
        bus.rx_valid = 0;
        chk("rx_full_rd", d, 32'd20);
        bus_rd(SA, 0, d);
        chk("rx_full_status", d, 32'h0004_0701);
        for (int i = 1; i <= 7; i++) begin
            bus_rd(DA, 0, d);
            chk("rx_seq2", d, 32'd20 + 32'(i));
        end
        // empty RX, read plus external push
        bus.rx_valid = 1;
        bus.rx_data = 32'h77;
        bus_rd(DA, 1, d);
        bus.rx_valid = 0;
        chk("rx_empty_push", d, 32'h0);
        bus_rd(DA, 1, d);
        chk("rx_retained", d, 32'h77);
        bus_wr(SA, 32'h1C, 0);

        // read and write together
        bus.address_Bus = DA;
        bus.Read_CPU = 1;
        bus.Write_CPU = 1;
        @(negedge CLK);
        chk("proto_rd", Data_Bus, 32'h0);
        tick();
        bus.Read_CPU = 0;
        bus.Write_CPU = 0;
        bus.address_Bus = '0;
        bus_rd(SA, 0, d);
        chk("proto_status", d, 32'h0004_0014);

        // asynchronous reset mid-cycle
        bus.rx_valid = 1;
        bus.rx_data = 32'h55;
        tick();
        bus.rx_valid = 0;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        chk("arst_rx_ready", {31'b0, bus.rx_ready}, 32'd1);
        tick();
        RST_N = 1'b1;
        bus_rd(SA, 0, d);
        chk("arst_status", d, 32'h0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
